// File: rtl/ws2822_dmx_controller.sv
// -----------------------------------------------------------------------------
// ws2822_dmx_controller
//
// Drives a chain of WS2822S DMX512 pixels. It has two modes of operation:
//   data    : one DMX frame on data_pin. The frame is a start code 0x00
//             followed by R,G,B for every buffered pixel.
//   program : the WS2822 address-programming sequence. The controller powers
//             up, sends the programming frame on address_pin, waits for the
//             pixels to settle, then power-cycles the LED supply.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   address[15:0]            start address to program (bits [8:0] are used)
//   program_strobe           1-cycle request for the programming sequence
//   data_strobe              1-cycle request for a data frame
//   pix_wr, pix_index        pixel buffer write enable and write index
//   red, green, blue         pixel write data
//   busy                     a sequence or a frame is in progress
//   prog_done                1-cycle pulse when the programming sequence ends
//   power_en                 LED supply enable
//   data_pin, address_pin    DMX data line and WS2822 ADRI line
// -----------------------------------------------------------------------------
module ws2822_dmx_controller #(
  parameter int CLK_DIV        = 48,
  parameter int BREAK_BITS     = 25,
  parameter int MAB_BITS       = 3,
  parameter int PIXELS         = 8,
  parameter int PWR_ON_CYCLES  = 120000,
  parameter int SETTLE_CYCLES  = 120000,
  parameter int PWR_OFF_CYCLES = 600000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic        program_strobe,
  input  logic        pix_wr,
  input  logic [7:0]  pix_index,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        data_strobe,
  output logic        busy,
  output logic        prog_done,
  output logic        power_en,
  output logic        data_pin,
  output logic        address_pin
);

  localparam int BREAK_CYC   = BREAK_BITS * CLK_DIV;
  localparam int MAB_CYC     = MAB_BITS * CLK_DIV;
  localparam int W_A         = (PWR_ON_CYCLES > SETTLE_CYCLES) ? PWR_ON_CYCLES : SETTLE_CYCLES;
  localparam int W_B         = (W_A > PWR_OFF_CYCLES) ? W_A : PWR_OFF_CYCLES;
  localparam int W_C         = (W_B > BREAK_CYC) ? W_B : BREAK_CYC;
  localparam int WAIT_MAX    = (W_C > MAB_CYC) ? W_C : MAB_CYC;
  localparam int WAIT_W      = $clog2(WAIT_MAX + 1);
  localparam int DIV_W       = $clog2(CLK_DIV + 1);
  localparam int NSLOTS_DATA = 1 + 3 * PIXELS;
  localparam int SLOT_W      = $clog2(NSLOTS_DATA + 1);
  localparam int PIX_W       = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [7:0] PIXELS_U8 = 8'(PIXELS);

  typedef enum logic [2:0] {
    IDLE, PWR_UP, BREAK, MAB, SLOT, SETTLE, PWR_OFF, PWR_UP2
  } state_t;

  state_t              state_q, state_d;
  logic                mode_prog_q;
  logic                pwr_q;
  logic [8:0]          addr_q;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_load;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [3:0]          bit_cnt_q;
  logic [SLOT_W-1:0]   slot_cnt_q, load_idx;
  logic [PIX_W-1:0]    pix_q;
  logic [1:0]          col_q;
  logic [10:0]         shreg_q;
  logic [7:0]          next_byte;
  logic                wait_done, bit_end, slot_end, last_slot, load_slot, tx_line;

  logic [7:0] red_mem   [PIXELS];
  logic [7:0] green_mem [PIXELS];
  logic [7:0] blue_mem  [PIXELS];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, address[15:9]};

  // NOTE: the pixel buffer is a plain RAM. It has no reset, so it can map
  // onto memory blocks, and its contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (pix_wr && (pix_index < PIXELS_U8)) begin
      red_mem[pix_index[PIX_W-1:0]]   <= red;
      green_mem[pix_index[PIX_W-1:0]] <= green;
      blue_mem[pix_index[PIX_W-1:0]]  <= blue;
    end
  end

  assign wait_done = (wait_cnt_q == '0);
  assign bit_end   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign slot_end  = bit_end && (bit_cnt_q == 4'd10);
  assign last_slot = (slot_cnt_q == (mode_prog_q ? SLOT_W'(3) : SLOT_W'(NSLOTS_DATA - 1)));
  assign load_slot = ((state_q == MAB) && (state_d == SLOT)) ||
                     ((state_q == SLOT) && slot_end && !last_slot);

  // NOTE: every variable in this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (program_strobe)   state_d = PWR_UP;  // program wins over data
        else if (data_strobe) state_d = pwr_q ? BREAK : PWR_UP;
      end
      PWR_UP:  if (wait_done) state_d = BREAK;
      BREAK:   if (wait_done) state_d = MAB;
      MAB:     if (wait_done) state_d = SLOT;
      SLOT:    if (slot_end && last_slot) state_d = mode_prog_q ? SETTLE : IDLE;
      SETTLE:  if (wait_done) state_d = PWR_OFF;
      PWR_OFF: if (wait_done) state_d = PWR_UP2;
      PWR_UP2: if (wait_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each timed state is entered with its length minus one. The state then
  // ends on the cycle in which the counter reaches zero.
  always_comb begin
    wait_load = '0;
    case (state_d)
      PWR_UP, PWR_UP2: wait_load = WAIT_W'(PWR_ON_CYCLES - 1);
      BREAK:           wait_load = WAIT_W'(BREAK_CYC - 1);
      MAB:             wait_load = WAIT_W'(MAB_CYC - 1);
      SETTLE:          wait_load = WAIT_W'(SETTLE_CYCLES - 1);
      PWR_OFF:         wait_load = WAIT_W'(PWR_OFF_CYCLES - 1);
      default:         wait_load = '0;
    endcase
  end

  // This block selects the byte for the slot whose start bit begins at the
  // next edge. The byte is read from the buffer at that edge, so a pixel
  // write lands only in slots that are not yet loaded.
  always_comb begin
    load_idx  = (state_q == SLOT) ? slot_cnt_q + SLOT_W'(1) : '0;
    next_byte = 8'h00;
    if (mode_prog_q) begin
      case (load_idx[1:0])
        2'd0:    next_byte = 8'hA0;
        2'd1:    next_byte = addr_q[7:0];
        2'd2:    next_byte = {7'b1111000, addr_q[8]};
        default: next_byte = 8'hD2;
      endcase
    end else if (load_idx != '0) begin
      case (col_q)
        2'd0:    next_byte = red_mem[pix_q];
        2'd1:    next_byte = green_mem[pix_q];
        default: next_byte = blue_mem[pix_q];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_prog_q <= 1'b0;
      pwr_q       <= 1'b0;
      prog_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_done <= (state_q == PWR_UP2) && (state_d == IDLE);
      if ((state_d == PWR_UP) || (state_d == PWR_UP2)) pwr_q <= 1'b1;
      else if (state_d == PWR_OFF)                     pwr_q <= 1'b0;
      if ((state_q == IDLE) && (state_d != IDLE)) mode_prog_q <= program_strobe;
    end
  end

  // Datapath registers. The FSM qualifies every one of them before its
  // value is used, so they need no reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && (state_d != IDLE)) addr_q <= address[8:0];

    if (state_d != state_q)  wait_cnt_q <= wait_load;
    else if (!wait_done)     wait_cnt_q <= wait_cnt_q - 1'b1;

    if (load_slot) begin
      shreg_q   <= {2'b11, next_byte, 1'b0};  // stop, stop, data LSB first, start
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (state_q == SLOT) begin
      if (bit_end) begin
        div_cnt_q <= '0;
        bit_cnt_q <= bit_cnt_q + 1'b1;
        shreg_q   <= {1'b1, shreg_q[10:1]};
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end

    if (state_q == MAB)                     slot_cnt_q <= '0;
    else if (state_q == SLOT && load_slot)  slot_cnt_q <= slot_cnt_q + 1'b1;

    if (state_q == IDLE) begin
      pix_q <= '0;
      col_q <= '0;
    end else if (load_slot && (load_idx != '0)) begin
      if (col_q == 2'd2) begin
        col_q <= '0;
        pix_q <= pix_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // This is the level of the line in use for the current mode. During
  // PWR_UP that line is held low, so power-up merges into the break.
  always_comb begin
    case (state_q)
      PWR_UP, BREAK: tx_line = 1'b0;
      SLOT:          tx_line = shreg_q[0];
      default:       tx_line = 1'b1;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign power_en    = pwr_q;
  assign data_pin    = pwr_q && ((state_q == IDLE) ? 1'b1 : (mode_prog_q ? 1'b0 : tx_line));
  assign address_pin = pwr_q && ((state_q == IDLE || !mode_prog_q) ? 1'b1 : tx_line);

endmodule

// File: tb/tb_ws2822_dmx_controller.sv
// -----------------------------------------------------------------------------
// tb_ws2822_dmx_controller
//
// Self-checking bench for ws2822_dmx_controller using small timing parameters.
// Each request pushes the expected slot bytes to a queue. The receiver pops
// one byte per decoded slot and compares it with the bits on the line. Line
// timing, power sequencing and handshake rules are checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_ws2822_dmx_controller;

  localparam int CLK_DIV = 4, BREAK_BITS = 2, MAB_BITS = 1, PIXELS = 2;
  localparam int PWR_ON = 10, SETTLE = 6, PWR_OFF = 8;
  localparam int SLOT_CYC = 11 * CLK_DIV;
  localparam int BOUND = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address = '0;
  logic        program_strobe = 1'b0;
  logic        data_strobe = 1'b0;
  logic        pix_wr = 1'b0;
  logic [7:0]  pix_index = '0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        busy, prog_done, power_en, data_pin, address_pin;

  always #5 clk = ~clk;

  ws2822_dmx_controller #(
    .CLK_DIV(CLK_DIV), .BREAK_BITS(BREAK_BITS), .MAB_BITS(MAB_BITS),
    .PIXELS(PIXELS), .PWR_ON_CYCLES(PWR_ON), .SETTLE_CYCLES(SETTLE),
    .PWR_OFF_CYCLES(PWR_OFF)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .program_strobe(program_strobe),
    .pix_wr(pix_wr), .pix_index(pix_index), .red(red), .green(green),
    .blue(blue), .data_strobe(data_strobe), .busy(busy),
    .prog_done(prog_done), .power_en(power_en), .data_pin(data_pin),
    .address_pin(address_pin)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int pd_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_r[PIXELS], m_g[PIXELS], m_b[PIXELS];

  always @(negedge clk) if (prog_done === 1'b1) pd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic write_pix(input logic [7:0] idx, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    pix_wr = 1'b1; pix_index = idx; red = r; green = g; blue = b;
    @(negedge clk);
    pix_wr = 1'b0;
    if (idx < PIXELS) begin
      m_r[idx] = r; m_g[idx] = g; m_b[idx] = b;
    end
  endtask

  task automatic push_data_frame();
    exp_q.push_back(8'h00);
    for (int i = 0; i < PIXELS; i++) begin
      exp_q.push_back(m_r[i]); exp_q.push_back(m_g[i]); exp_q.push_back(m_b[i]);
    end
  endtask

  task automatic push_prog_frame(input logic [8:0] a);
    exp_q.push_back(8'hA0);
    exp_q.push_back(a[7:0]);
    exp_q.push_back({7'b1111000, a[8]});
    exp_q.push_back(8'hD2);
  endtask

  // Leaves the bench on the first sample after the strobe edge.
  task automatic pulse(input logic p, input logic d);
    @(negedge clk);
    program_strobe = p; data_strobe = d;
    @(negedge clk);
    program_strobe = 1'b0; data_strobe = 1'b0;
  endtask

  function automatic logic line_of(input bit on_addr);
    return on_addr ? address_pin : data_pin;
  endfunction

  function automatic bit other_ok(input bit on_addr);
    return (power_en === 1'b1) && (busy === 1'b1) &&
           (on_addr ? (data_pin === 1'b0) : (address_pin === 1'b1));
  endfunction

  task automatic recv_frame(input bit on_addr, input string tag, input int exp_low,
                            output int total);
    int n, other_bad, glitch;
    logic [10:0] fr;
    logic smp;
    logic [7:0] e;
    total = 0; other_bad = 0; glitch = 0;
    n = 0;
    while (line_of(on_addr) === 1'b0 && n < BOUND) begin
      if (!other_ok(on_addr)) other_bad++;
      n++; @(negedge clk);
    end
    check({tag, "_low_len"}, n, exp_low);
    total += n;
    n = 0;
    while (line_of(on_addr) === 1'b1 && n < BOUND) begin
      if (!other_ok(on_addr)) other_bad++;
      n++; @(negedge clk);
    end
    check({tag, "_mab_len"}, n, MAB_BITS * CLK_DIV);
    total += n;
    while (exp_q.size() > 0) begin
      fr = '0;
      for (int b = 0; b < 11; b++) begin
        for (int c = 0; c < CLK_DIV; c++) begin
          smp = line_of(on_addr);
          if (c == 0) fr[b] = smp;
          else if (smp !== fr[b]) glitch++;
          if (!other_ok(on_addr)) other_bad++;
          @(negedge clk);
        end
      end
      total += SLOT_CYC;
      e = exp_q.pop_front();
      check({tag, "_slot"}, fr, {2'b11, e, 1'b0});
    end
    check({tag, "_bit_stable"}, glitch, 0);
    check({tag, "_other_lines"}, other_bad, 0);
  endtask

  // Called on the first SETTLE sample. When poke is set, data_strobe is
  // held high through SETTLE and PWR_OFF; the controller must ignore it.
  task automatic program_tail(input string tag, input bit poke);
    int n, bad;
    bad = 0;
    if (poke) data_strobe = 1'b1;
    n = 0;
    while (power_en === 1'b1 && busy === 1'b1 && n < BOUND) begin
      if (data_pin !== 1'b0) bad++;
      n++; @(negedge clk);
    end
    check({tag, "_settle_len"}, n, SETTLE);
    n = 0;
    while (power_en === 1'b0 && n < BOUND) begin
      if (data_pin !== 1'b0 || address_pin !== 1'b0 || busy !== 1'b1) bad++;
      n++; @(negedge clk);
    end
    check({tag, "_off_len"}, n, PWR_OFF);
    data_strobe = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < BOUND) begin
      if (power_en !== 1'b1 || data_pin !== 1'b0) bad++;
      n++; @(negedge clk);
    end
    check({tag, "_up2_len"}, n, PWR_ON);
    check({tag, "_tail_lines"}, bad, 0);
    check({tag, "_done_pulse"}, prog_done, 1'b1);
    check({tag, "_power_after"}, power_en, 1'b1);
    @(negedge clk);
    check({tag, "_done_clear"}, prog_done, 1'b0);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (busy !== 1'b0 || data_pin !== 1'b1 || address_pin !== 1'b1) bad++;
      @(negedge clk);
    end
    check({tag, "_idle"}, bad, 0);
  endtask

  initial begin
    int total, pd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_power", power_en, 1'b0);
    check("rst_data", data_pin, 1'b0);
    check("rst_addr", address_pin, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", prog_done, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_quiet", {busy, power_en, data_pin, address_pin, prog_done}, 5'b0);

    // Cold data frame
    write_pix(8'd0, 8'h12, 8'h34, 8'h56);
    write_pix(8'd1, 8'hAA, 8'h55, 8'h01);
    push_data_frame();
    pulse(1'b0, 1'b1);
    check("cold_busy", busy, 1'b1);
    check("cold_power", power_en, 1'b1);
    recv_frame(1'b0, "cold", PWR_ON + BREAK_BITS * CLK_DIV, total);
    check("cold_busy_end", busy, 1'b0);
    check("cold_power_hold", power_en, 1'b1);
    idle_watch("cold", 5);

    // Warm data frame
    push_data_frame();
    pulse(1'b0, 1'b1);
    check("warm_busy", busy, 1'b1);
    check("warm_data_fall", data_pin, 1'b0);
    recv_frame(1'b0, "warm", BREAK_BITS * CLK_DIV, total);
    check("warm_frame_len", total, 320);
    check("warm_busy_end", busy, 1'b0);

    // Program 0x13F; the ignored upper address bits are set
    address = 16'hFF3F;
    push_prog_frame(9'h13F);
    pd0 = pd_cnt;
    pulse(1'b1, 1'b0);
    address = 16'h0000;
    check("prog_busy", busy, 1'b1);
    recv_frame(1'b1, "prog", PWR_ON + BREAK_BITS * CLK_DIV, total);
    program_tail("prog", 1'b0);
    check("prog_done_count", pd_cnt - pd0, 1);

    // Simultaneous strobes: program wins; data strobe mid-sequence dropped
    address = 16'h00A5;
    push_prog_frame(9'h0A5);
    pd0 = pd_cnt;
    pulse(1'b1, 1'b1);
    recv_frame(1'b1, "both", PWR_ON + BREAK_BITS * CLK_DIV, total);
    program_tail("both", 1'b1);
    check("both_done_count", pd_cnt - pd0, 1);
    idle_watch("no_extra_frame", 30);

    // Out-of-range write leaves the buffer unchanged
    write_pix(8'd2, 8'hFF, 8'hEE, 8'hDD);
    push_data_frame();
    pulse(1'b0, 1'b1);
    recv_frame(1'b0, "oor", BREAK_BITS * CLK_DIV, total);

    // Reset during slot 3
    pulse(1'b0, 1'b1);
    repeat ((BREAK_BITS + MAB_BITS) * CLK_DIV + 3 * SLOT_CYC + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {busy, power_en, data_pin, address_pin, prog_done}, 5'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_quiet", {busy, power_en}, 2'b0);

    // Cold frame after reset; the buffer must still hold the pixel data
    push_data_frame();
    pulse(1'b0, 1'b1);
    recv_frame(1'b0, "post_rst", PWR_ON + BREAK_BITS * CLK_DIV, total);
    check("post_rst_busy_end", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ws2822_dmx_controller.md
Name: ws2822_dmx_controller

Overview:
Drives a chain of WS2822S DMX512 LED pixels from one FPGA clock domain, including the built-in DMX transmitter. Two modes:
- Data: sends a DMX frame of buffered RGB values on data_pin.
- Program: runs the full address-programming sequence (power up, programming frame on address_pin, settle, power cycle).
Sits between the Wi-Fi/SPI register interface and the LED power switch and data/address line drivers.

Parameters:
CLK_DIV, 48, clk cycles per DMX bit (12 MHz / 250 kbaud)
BREAK_BITS, 25, break length in bit times (100 us)
MAB_BITS, 3, mark-after-break length in bit times (12 us)
PIXELS, 8, pixels in buffer and data frame (1..170)
PWR_ON_CYCLES, 120000, wait after power_en rises before any frame
SETTLE_CYCLES, 120000, wait after programming frame before power-off
PWR_OFF_CYCLES, 600000, power-off time during programming power cycle

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
address  in  16  start address to program; bits [8:0] used, [15:9] ignored
program_strobe  in  1  1-cycle request: run programming sequence
pix_wr  in  1  write red/green/blue into buffer at pix_index
pix_index  in  8  pixel index, 0..PIXELS-1
red  in  8  pixel red
green  in  8  pixel green
blue  in  8  pixel blue
data_strobe  in  1  1-cycle request: send data frame
busy  out  1  sequence or frame in progress
prog_done  out  1  1-cycle pulse at end of programming sequence
power_en  out  1  LED supply enable
data_pin  out  1  DMX data line
address_pin  out  1  WS2822 ADRI line

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: power_en=0, data_pin=0, address_pin=0, busy=0, prog_done=0, FSM=IDLE. The pixel buffer is not cleared.
- Line levels:
  - power_en=0: both lines driven 0, so unpowered LEDs are never back-driven.
  - power_en=1 and a line is not transmitting: that line idles at 1 (mark).
  - During programming, data_pin is held 0 throughout.
- DMX byte format: start bit 0, 8 data bits LSB first, 2 stop bits 1. That is 11 bit times; every bit lasts exactly CLK_DIV cycles.
- Frame: BREAK (line 0 for BREAK_BITS*CLK_DIV cycles), then MAB (line 1 for MAB_BITS*CLK_DIV cycles), then slots back-to-back with no inter-slot gap.
- Data frame (on data_pin):
  - Slots: start code 0x00, then R,G,B for pixel 0..PIXELS-1.
  - Each slot byte is read from the buffer when its start bit begins.
- Programming frame (on address_pin):
  - Slots: 0xA0, address[7:0], {7'b1111000, address[8]}, 0xD2.
- FSM states: IDLE, PWR_UP, BREAK, MAB, SLOT, SETTLE, PWR_OFF, PWR_UP2. A mode flag (data/program) is latched on strobe acceptance.
- Data transitions:
  - IDLE -> BREAK if already powered.
  - Otherwise IDLE -> PWR_UP (power_en=1, wait PWR_ON_CYCLES) -> BREAK.
  - Then MAB -> SLOT(last) -> IDLE.
- Program transitions:
  - IDLE -> PWR_UP. power_en=1; the full PWR_ON_CYCLES wait applies even if already powered.
  - PWR_UP -> BREAK -> MAB -> SLOT(4 slots) -> SETTLE (SETTLE_CYCLES).
  - SETTLE -> PWR_OFF (power_en=0, PWR_OFF_CYCLES) -> PWR_UP2 (power_en=1, PWR_ON_CYCLES) -> IDLE.
  - prog_done pulses in the first IDLE cycle.
- Latency:
  - A strobe at cycle t gives busy=1 at t+1.
  - If powered, data_pin also falls at t+1.
  - busy=0 in the cycle after the last stop bit (data mode) or after PWR_UP2 (program mode).
  - Data frame length when powered: (BREAK_BITS+MAB_BITS+11*(1+3*PIXELS))*CLK_DIV cycles.
- Handshake:
  - Strobes are accepted only in IDLE; strobes while busy are dropped, not queued.
  - Simultaneous program_strobe and data_strobe: program wins, data is dropped.
- Buffer:
  - pix_wr is accepted in any state; it takes effect on the next cycle.
  - A write during a frame affects only slots not yet loaded.
  - pix_index >= PIXELS: write ignored.
- Power persists after a data frame; power_en stays 1 until reset or the programming power cycle.
- Reset mid-operation: on the next cycle all outputs return to reset values (power_en=0) and the FSM is IDLE.
- Counters: bit timer sized for max(CLK_DIV, ...); wait counter sized for the largest of PWR_ON/SETTLE/PWR_OFF_CYCLES.

Test Plan:
All tests use CLK_DIV=4, BREAK_BITS=2, MAB_BITS=1, PIXELS=2, PWR_ON_CYCLES=10, SETTLE_CYCLES=6, PWR_OFF_CYCLES=8.
1. Reset asserted 3 cycles -> power_en=data_pin=address_pin=busy=prog_done=0. Release -> outputs unchanged, no activity.
2. Cold data frame:
   - Stimulus: write px0=(0x12,0x34,0x56), px1=(0xAA,0x55,0x01); pulse data_strobe.
   - Response: power_en=1 at t+1; data_pin 0 for 10 cycles; then 0 for 8 (break); 1 for 4 (MAB).
   - Then slots 00,12,34,56,AA,55,01, each 44 cycles, LSB first 8N2; address_pin=1 throughout; busy falls after 7*44 slot cycles.
3. Second data_strobe while powered -> break starts at t+1; frame total 12+308=320 cycles.
4. Program address 0x13F:
   - address_pin carries A0,3F,F1,D2; data_pin=0 throughout.
   - power_en=0 for exactly 8 cycles after settle, then 1 for 10 cycles.
   - prog_done pulses once; busy=0 the same cycle.
5. Handshake:
   - data_strobe mid-programming -> ignored, no extra frame.
   - Simultaneous program_strobe+data_strobe in IDLE -> programming frame only.
6. Buffer edges and reset:
   - Write pix_index=2 (out of range) -> buffer unchanged; next frame slots still 00,12,34,56,AA,55,01.
   - rst during slot 3 -> next cycle all outputs 0, busy=0.
